// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions: opcode constants, field widths and instruction
// format classification. The decoder imports the same package.
package isa_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned OFF_W  = 26;
  localparam int unsigned MODE_W = 2;

  localparam logic [OP_W-1:0] OP_AND    = 6'h00;
  localparam logic [OP_W-1:0] OP_ADD    = 6'h01;
  localparam logic [OP_W-1:0] OP_SUB    = 6'h02;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'h03;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h04;
  localparam logic [OP_W-1:0] OP_LW     = 6'h05;
  localparam logic [OP_W-1:0] OP_LW_POI = 6'h06;
  localparam logic [OP_W-1:0] OP_SW     = 6'h07;
  localparam logic [OP_W-1:0] OP_BGT    = 6'h08;
  localparam logic [OP_W-1:0] OP_BLT    = 6'h09;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h0A;
  localparam logic [OP_W-1:0] OP_BNE    = 6'h0B;
  localparam logic [OP_W-1:0] OP_JMP    = 6'h0C;
  localparam logic [OP_W-1:0] OP_CALL   = 6'h0D;
  localparam logic [OP_W-1:0] OP_RET    = 6'h0E;
  localparam logic [OP_W-1:0] OP_PUSH   = 6'h0F;
  localparam logic [OP_W-1:0] OP_POP    = 6'h10;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_S} fmt_t;

  // RET and any unknown opcode classify as J-type; RET's offset zeroing is
  // handled by the packer.
  function automatic fmt_t fmt_of(input logic [OP_W-1:0] op);
    fmt_t f;
    if (op <= OP_SUB)                         f = FMT_R;
    else if (op <= OP_BNE)                    f = FMT_I;
    else if (op == OP_PUSH || op == OP_POP)   f = FMT_S;
    else                                      f = FMT_J;
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// instr_fifo: synchronous DEPTH x W FIFO. Push when full and pop when empty
// are ignored. DEPTH must be a power of two (pointers wrap naturally).
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 32-bit words, buffers
// them in instr_fifo and writes them to instruction memory at sequential
// addresses under mem_ready backpressure.
// Optional macro ENC_OPCODE_CHECK_EN: drop opcodes above POP and report them
// on err_illegal / err_count; otherwise unknown opcodes are packed raw.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned        DEPTH     = 4,
  parameter int unsigned        ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [15:0]       in_imm,
  input  logic [1:0]        in_mode,
  input  logic [25:0]       in_offset,
  input  logic              addr_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err_illegal,
  output logic [7:0]        err_count
);

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] word;

  assign in_ready = !fifo_full;
  assign mem_we   = !fifo_empty;
  assign busy     = !fifo_empty;
  assign accept   = in_valid && in_ready;
  assign pop      = mem_we && mem_ready;

  // Field packing by format; unused bits are zero.
  always_comb begin
    word = '0;
    case (fmt_of(in_opcode))
      FMT_R:   word = {in_opcode, in_rd, in_rs1, in_rs2, 14'b0};
      FMT_I:   word = {in_opcode, in_rd, in_rs1, in_imm, in_mode};
      FMT_S:   word = {in_opcode, in_rd, 22'b0};
      default: word = (in_opcode == OP_RET) ? {in_opcode, 26'b0}
                                            : {in_opcode, in_offset};
    endcase
  end

`ifdef ENC_OPCODE_CHECK_EN
  logic illegal;
  assign illegal = (in_opcode > OP_POP);
  assign push    = accept && !illegal;

  // Illegal-opcode pulse and saturating count, updated on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= accept && illegal;
      if (accept && illegal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  assign push        = accept;
  assign err_illegal = 1'b0;
  assign err_count   = '0;
`endif

  // Write address counter; addr_clr overrides the pop increment.
  always_ff @(posedge clk) begin
    if (rst || addr_clr) mem_addr <= BASE_ADDR;
    else if (pop)        mem_addr <= mem_addr + ADDR_W'(1);
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (mem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected {addr, word}
// entries; monitors pop and compare on every accepted memory write. A second
// instance with ADDR_W=2 covers address wrap and addr_clr.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_s;
  logic        in_valid, in_valid_s;
  logic        addr_clr, addr_clr_s;
  logic        mem_ready, mem_ready_s;
  logic [5:0]  in_opcode;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [25:0] in_offset;

  logic        in_ready, mem_we, busy, err_illegal;
  logic [7:0]  mem_addr, err_count;
  logic [31:0] mem_wdata;

  logic        in_ready_s, mem_we_s, busy_s, err_illegal_s;
  logic [1:0]  mem_addr_s;
  logic [7:0]  err_count_s;
  logic [31:0] mem_wdata_s;

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_mode(in_mode), .in_offset(in_offset),
    .addr_clr(addr_clr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
    .err_illegal(err_illegal), .err_count(err_count)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_mode(in_mode), .in_offset(in_offset),
    .addr_clr(addr_clr_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .mem_ready(mem_ready_s), .busy(busy_s),
    .err_illegal(err_illegal_s), .err_count(err_count_s)
  );

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_qs[$];
  logic [7:0]  addr_m  = 8'd0;
  logic [7:0]  addr_ms = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the main instance.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL big_unexpected_write: got addr %h data %h expected none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("big_addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
        chk("big_data", mem_wdata, e[31:0]);
      end
    end
  end

  // Monitor for the narrow-address instance.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst_s && mem_we_s && mem_ready_s) begin
      if (exp_qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL small_unexpected_write: got addr %h data %h expected none", mem_addr_s, mem_wdata_s);
      end else begin
        e = exp_qs.pop_front();
        chk("small_addr", {30'd0, mem_addr_s}, {24'd0, e[39:32]});
        chk("small_data", mem_wdata_s, e[31:0]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  // a < 0 selects the running address model.
  task automatic send(input bit s, input logic [5:0] op, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic [15:0] imm, input logic [1:0] mode,
                      input logic [25:0] off, input bit exp_push,
                      input logic [31:0] word, input int a);
    int unsigned n = 0;
    while (!(s ? in_ready_s : in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!(s ? in_ready_s : in_ready)) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      return;
    end
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_mode = mode; in_offset = off;
    if (s) in_valid_s = 1'b1; else in_valid = 1'b1;
    if (exp_push) begin
      if (s) begin
        exp_qs.push_back({(a < 0) ? addr_ms : 8'(a), word});
        addr_ms = (addr_ms + 8'd1) & 8'd3;
      end else begin
        exp_q.push_back({(a < 0) ? addr_m : 8'(a), word});
        addr_m = addr_m + 8'd1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_s = 1'b0;
  endtask

  task automatic wait_idle(input bit s);
    int unsigned n = 0;
    while ((s ? busy_s : busy) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (s ? busy_s : busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: busy got 1 expected 0");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst_s = 1'b1;
    in_valid = 1'b0; in_valid_s = 1'b0;
    addr_clr = 1'b0; addr_clr_s = 1'b0;
    mem_ready = 1'b1; mem_ready_s = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_mode = '0; in_offset = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    rst = 1'b0; rst_s = 1'b0;
    @(posedge clk); #1;

    // ADD: latency 1 to mem_we
    send(0, 6'h01, 4'd2, 4'd3, 4'd4, 16'h0, 2'd0, 26'h0, 1, 32'h048D0000, -1);
    chk("add_latency_mem_we", {31'd0, mem_we}, 32'd1);
    // ADDI, JMP, RET with stray offset
    send(0, 6'h04, 4'd5, 4'd6, 4'd0, 16'd10, 2'b01, 26'h0, 1, 32'h11580029, -1);
    send(0, 6'h0C, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'd15, 1, 32'h3000000F, -1);
    send(0, 6'h0E, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'h3FFFFFF, 1, 32'h38000000, -1);
    // PUSH with stray fields
    send(0, 6'h0F, 4'd7, 4'hF, 4'hF, 16'hFFFF, 2'b11, 26'h3FFFFFF, 1, 32'h3DC00000, -1);
    // SUB with all-ones registers
    send(0, 6'h02, 4'hF, 4'hF, 4'hF, 16'hFFFF, 2'b11, 26'h0, 1, 32'h0BFFC000, -1);
    wait_idle(0);

    // Return address to base while idle
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    addr_m = 8'd0;
    chk("addr_clr_idle", {24'd0, mem_addr}, 32'd0);

    // Backpressure: 4 accepted, 5th blocked
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(0, 6'h0C, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'(i + 100), 1, {6'h0C, 26'(i + 100)}, -1);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_mem_addr_hold", {24'd0, mem_addr}, 32'd0);
    chk("bp_mem_we_high", {31'd0, mem_we}, 32'd1);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
    send(0, 6'h0D, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'd104, 1, {6'h0D, 26'd104}, -1);
    wait_idle(0);
    chk("bp_final_addr", {24'd0, mem_addr}, 32'd5);

    // Illegal opcode handling
`ifdef ENC_OPCODE_CHECK_EN
    send(0, 6'h11, 4'd1, 4'd1, 4'd1, 16'h1, 2'd1, 26'h55, 0, 32'h0, -1);
    chk("illegal_pulse", {31'd0, err_illegal}, 32'd1);
    chk("illegal_count1", {24'd0, err_count}, 32'd1);
    chk("illegal_no_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("illegal_pulse_end", {31'd0, err_illegal}, 32'd0);
    chk("illegal_no_we_later", {31'd0, mem_we}, 32'd0);
    for (int i = 0; i < 299; i++)
      send(0, 6'h3F, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'(i), 0, 32'h0, -1);
    chk("illegal_saturate", {24'd0, err_count}, 32'd255);
`else
    send(0, 6'h11, 4'd1, 4'd1, 4'd1, 16'h1, 2'd1, 26'h55, 1, 32'h44000055, -1);
    chk("raw_mem_we", {31'd0, mem_we}, 32'd1);
    chk("raw_err_illegal", {31'd0, err_illegal}, 32'd0);
    for (int i = 0; i < 299; i++)
      send(0, 6'h3F, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'(i), 1, {6'h3F, 26'(i)}, -1);
    chk("raw_err_count", {24'd0, err_count}, 32'd0);
`endif
    wait_idle(0);

    // Reset while a write is pending
    mem_ready = 1'b0;
    send(0, 6'h01, 4'd1, 4'd1, 4'd1, 16'h0, 2'd0, 26'h0, 0, 32'h0, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstmid_mem_addr", {24'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    addr_m = 8'd0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_still_idle", {31'd0, mem_we}, 32'd0);

    // Narrow address: wrap 0,1,2,3,0
    for (int i = 0; i < 5; i++)
      send(1, 6'h0C, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'(i + 1), 1, {6'h0C, 26'(i + 1)}, -1);
    wait_idle(1);

    // Narrow address: addr_clr during the 3rd write
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
    addr_ms = 8'd0;
    mem_ready_s = 1'b0;
    send(1, 6'h0C, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'd20, 1, {6'h0C, 26'd20}, 0);
    send(1, 6'h0C, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'd21, 1, {6'h0C, 26'd21}, 1);
    send(1, 6'h0C, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'd22, 1, {6'h0C, 26'd22}, 2);
    send(1, 6'h0C, 4'd0, 4'd0, 4'd0, 16'h0, 2'd0, 26'd23, 1, {6'h0C, 26'd23}, 0);
    mem_ready_s = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr_clr_s = 1'b1;
    @(posedge clk); #1;
    addr_clr_s = 1'b0;
    wait_idle(1);
    chk("small_final_addr", {30'd0, mem_addr_s}, 32'd1);

    @(posedge clk); #1;
    chk("big_queue_empty", exp_q.size(), 32'd0);
    chk("small_queue_empty", exp_qs.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
